wb_uart_tx: RTL and testbench
=============================

Name: wb_uart_tx

Overview:
- Wishbone-attached UART transmitter: the counterpart of the buffered-RX UART slave.
- CPU writes bytes into a TX FIFO. A baud-timed FSM drains them onto uart_txd as 8N1 frames (start bit, LSB first).
- Sits on the same Wishbone bus as the RX UART.
- Provides status, flush, overflow flag and a TX-done interrupt.

Parameters:
- ADDR_WIDTH, "mandatory", Wishbone address width.
- DATA_WIDTH, "mandatory", Wishbone data width (≥16).
- SYS_FREQ_HZ, "mandatory", clk frequency.
- BAUD_RATE, "mandatory", line rate. DIVISOR = (SYS_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE.
- FIFO_ADDR_SIZE, 4, TX FIFO depth = 2^FIFO_ADDR_SIZE (≤7).
- UART_DATA_WIDTH, 8, data bits per frame.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-high reset (asserted = 1).
- wb_stb_i  in  1  Wishbone strobe.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte select (ignored).
- wb_adr_i  in  ADDR_WIDTH  register select, uses [1:0].
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data, registered.
- wb_ack_o  out  1  single-cycle acknowledge.
- uart_txd  out  1  serial output, idle high.
- tx_irq  out  1  level interrupt.

Behaviour:
- Reset: uart_txd=1, wb_ack_o=0, wb_dat_o=0, tx_irq=0, FIFO empty, overflow=0, irq_en=0, FSM in S_IDLE, baud counter 0.
- Reset mid-frame aborts the frame; uart_txd returns high asynchronously.
- Bus access: access = stb & cyc & ~wb_ack_o.
  - ack is registered: asserted the edge after the access, for exactly one cycle. No back-to-back ack.
  - Write side effects take effect on the same edge that raises ack.
- Register map (wb_adr_i[1:0]):
  - 0 DATA (W): push wb_dat_i[7:0]. If the FIFO is full, the byte is dropped, overflow is set and ack is still given.
  - 1 STATUS (R): bit0 fifo_empty, bit1 fifo_full, bit2 tx_busy, bit3 overflow, bits[15:8] fifo level. Other bits 0.
  - 2 CTRL (W): bit0 flush (one-shot), bit1 clear overflow (one-shot), bit2 irq_en (persistent).
  - 3 reserved: reads 0, writes acked and ignored.
  - Reads of DATA and CTRL return 0.
- FIFO full/empty: full and empty are evaluated before the edge. A push while full is rejected even if a pop happens on that same edge.
- Flush: pointers and level go to 0. The frame already in the shift register completes normally.
- FSM states: S_IDLE, S_START, S_DATA, S_STOP. Baud counter counts DIVISOR-1 down to 0 per bit; bit_done = (cnt==0).
  - S_IDLE: txd=1. If FIFO not empty: pop into shift reg, load counter, go to S_START.
    - A byte pushed on edge E is popped on edge E+1; txd falls at E+1.
  - S_START: txd=0 for DIVISOR cycles, then go to S_DATA with bit index 0.
  - S_DATA: txd=shift[0] for DIVISOR cycles per bit, shift right. After UART_DATA_WIDTH bits, go to S_STOP.
  - S_STOP: txd=1 for DIVISOR cycles. At bit_done: if FIFO not empty, pop and go directly to S_START (no idle gap); else go to S_IDLE.
- tx_busy = (state != S_IDLE).
- tx_irq = irq_en & fifo_empty & ~tx_busy, registered (one-cycle delay).

Optional Feature:
- Macro: WB_UART_TX_PARITY_EN.
- Defined: adds state S_PARITY between S_DATA and S_STOP, lasting DIVISOR cycles. txd = XOR of data bits (even parity). Frame is 11 bits.
- Undefined: S_PARITY does not exist; frame is 10 bits.

Decomposition:
- Package wb_uart_tx_pkg:
  - FSM state encodings.
  - Register offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2).
  - STATUS/CTRL bit positions.
  - DIVISOR function.
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, flush, full, empty and a FIFO_ADDR_SIZE+1-bit level output.

Test Plan:
All scenarios use SYS_FREQ_HZ=1_000_000, BAUD_RATE=100_000 (DIVISOR=10), FIFO_ADDR_SIZE=4.
1. Write 0x55 to DATA -> txd low for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high. Falling edge occurs 1 cycle after the push edge; frame length 100 cycles.
2. Write 0xA1, 0x00, 0xFF back-to-back -> 300 contiguous cycles of framing, no idle between stop and start; STATUS level reads 2 after the first pop.
3. Write 18 bytes while idle -> first byte popped, 16 queued, 18th dropped; STATUS = full=1, overflow=1, level=16. CTRL bit1 write -> overflow=0.
4. Queue 5 bytes, write CTRL=0x1 mid first frame -> first frame completes, level=0, uart_txd stays high afterwards.
5. Set irq_en, write 1 byte -> tx_irq=0 while busy; tx_irq=1 one cycle after stop bit ends. Clearing irq_en drops it.
6. Assert resetn mid data bit -> uart_txd=1 immediately, STATUS reads 0x0001 after release, no residual frame.

Source files
------------

// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter.
//   - tx_state_e : transmit FSM states (StParity only with WB_UART_TX_PARITY_EN)
//   - REG_*      : register offsets decoded from wb_adr_i[1:0]
//   - STATUS_* / CTRL_* : bit positions inside the STATUS and CTRL registers
//   - calc_divisor : clocks per bit, rounded to nearest
// Optional feature macro: WB_UART_TX_PARITY_EN (even parity bit after the data bits).
package wb_uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef WB_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } tx_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned STATUS_EMPTY     = 0;
  localparam int unsigned STATUS_FULL      = 1;
  localparam int unsigned STATUS_BUSY      = 2;
  localparam int unsigned STATUS_OVF       = 3;
  localparam int unsigned STATUS_LEVEL_LSB = 8;

  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  function automatic int unsigned calc_divisor(input int unsigned sys_freq_hz,
                                               input int unsigned baud_rate);
    return (sys_freq_hz + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone slave bus bundle for wb_uart_tx.
//   master : drives stb/cyc/we/sel/adr/dat_i, samples dat_o/ack_o
//   slave  : the UART side, returns registered dat_o and single-cycle ack_o
interface wb_uart_tx_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic                  wb_we_i;
  logic [3:0]            wb_sel_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be transmitted.
//   clk, resetn : clock, asynchronous active-high reset
//   push_i      : write wdata_i (ignored when full, judged before the edge)
//   pop_i       : advance read pointer (ignored when empty); rdata_o is the head
//   flush_i     : discard all content (wins over push/pop)
//   full_o, empty_o, level_o : occupancy, level is FIFO_ADDR_SIZE+1 bits
module uart_tx_fifo #(
  parameter int unsigned FIFO_ADDR_SIZE = 4,
  parameter int unsigned WIDTH          = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [FIFO_ADDR_SIZE:0] level_o
);
  localparam int unsigned Depth = 2 ** FIFO_ADDR_SIZE;
  localparam logic [FIFO_ADDR_SIZE:0] DepthLevel = Depth[FIFO_ADDR_SIZE:0];

  logic [WIDTH-1:0]          mem_q [Depth];
  logic [FIFO_ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_SIZE:0]   level_q, level_d;
  logic                      do_push, do_pop;

  assign full_o  = (level_q == DepthLevel);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level_q gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-attached UART transmitter (8N1, LSB first) with a byte FIFO.
//   clk, resetn : clock, asynchronous active-high reset
//   wb          : Wishbone slave (wb_uart_tx_if.slave); regs at wb_adr_i[1:0]
//                 0 DATA(W) push byte, 1 STATUS(R), 2 CTRL(W) flush/clr_ovf/irq_en
//   uart_txd    : serial output, idle high
//   tx_irq      : level interrupt, irq_en & fifo empty & transmitter idle (registered)
// Optional feature macro: WB_UART_TX_PARITY_EN adds an even parity bit (11-bit frame).
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SYS_FREQ_HZ     = 1_000_000,
  parameter int unsigned BAUD_RATE       = 100_000,
  parameter int unsigned FIFO_ADDR_SIZE  = 4,
  parameter int unsigned UART_DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  wb_uart_tx_if.slave  wb,
  output logic         uart_txd,
  output logic         tx_irq
);
  localparam int unsigned DIVISOR = calc_divisor(SYS_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CntW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned IdxW    = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(DIVISOR - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(UART_DATA_WIDTH - 1);

  // Bus side
  logic                        access, wr_access, rd_access, ctrl_wr, fifo_push, fifo_flush;
  logic [1:0]                  reg_sel;
  logic [DATA_WIDTH-1:0]       status;
  logic                        ack_q, ack_d;
  logic [DATA_WIDTH-1:0]       dat_q, dat_d;
  logic                        ovf_q, ovf_d;
  logic                        irq_en_q, irq_en_d;
  logic                        tx_irq_q, tx_irq_d;
  logic                        unused_bus;

  // FIFO
  logic                        fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_WIDTH-1:0]  fifo_rdata;
  logic [FIFO_ADDR_SIZE:0]     fifo_level;

  // Transmit FSM
  tx_state_e                   state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [UART_DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                        txd_q, txd_d;
  logic                        bit_done, load_frame;
`ifdef WB_UART_TX_PARITY_EN
  logic                        par_q, par_d;
`endif

  assign reg_sel    = wb.wb_adr_i[1:0];
  assign access     = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr_access  = access & wb.wb_we_i;
  assign rd_access  = access & ~wb.wb_we_i;
  assign fifo_push  = wr_access & (reg_sel == REG_DATA);
  assign ctrl_wr    = wr_access & (reg_sel == REG_CTRL);
  assign fifo_flush = ctrl_wr & wb.wb_dat_i[CTRL_FLUSH];
  assign unused_bus = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i};

  uart_tx_fifo #(
    .FIFO_ADDR_SIZE (FIFO_ADDR_SIZE),
    .WIDTH          (UART_DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (wb.wb_dat_i[UART_DATA_WIDTH-1:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    status                              = '0;
    status[STATUS_EMPTY]                = fifo_empty;
    status[STATUS_FULL]                 = fifo_full;
    status[STATUS_BUSY]                 = (state_q != StIdle);
    status[STATUS_OVF]                  = ovf_q;
    status[STATUS_LEVEL_LSB +: 8]       = 8'(fifo_level);
  end

  always_comb begin
    ack_d    = access;
    dat_d    = (rd_access && reg_sel == REG_STATUS) ? status : '0;
    ovf_d    = ovf_q;
    if (fifo_push && fifo_full) begin
      ovf_d = 1'b1;
    end else if (ctrl_wr && wb.wb_dat_i[CTRL_CLR_OVF]) begin
      ovf_d = 1'b0;
    end
    irq_en_d = ctrl_wr ? wb.wb_dat_i[CTRL_IRQ_EN] : irq_en_q;
    tx_irq_d = irq_en_q & fifo_empty & (state_q == StIdle);
  end

  assign bit_done = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    fifo_pop   = 1'b0;
    load_frame = 1'b0;
`ifdef WB_UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    if (state_q != StIdle && !bit_done) cnt_d = cnt_q - 1'b1;

    unique case (state_q)
      StIdle: begin
        txd_d      = 1'b1;
        load_frame = ~fifo_empty;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          idx_d   = '0;
          cnt_d   = CntLoad;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = CntLoad;
          if (idx_q == LastIdx) begin
`ifdef WB_UART_TX_PARITY_EN
            state_d = StParity;
            txd_d   = par_q;
`else
            state_d = StStop;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef WB_UART_TX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          cnt_d   = CntLoad;
          txd_d   = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_d = StIdle;
            txd_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_frame) begin
      fifo_pop = 1'b1;
      state_d  = StStart;
      cnt_d    = CntLoad;
      shift_d  = fifo_rdata;
      txd_d    = 1'b0;
`ifdef WB_UART_TX_PARITY_EN
      par_d    = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      tx_irq_q <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef WB_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      tx_irq_q <= tx_irq_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef WB_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign uart_txd    = txd_q;
  assign tx_irq      = tx_irq_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: directed bus traffic, expected bytes and
// expected read data queued at issue time, monitors decode txd frames and read acks.
module tb_wb_uart_tx;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DIV = 10;
`ifdef WB_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * DIV;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic uart_txd, tx_irq;

  wb_uart_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  wb_uart_tx #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .SYS_FREQ_HZ     (1_000_000),
    .BAUD_RATE       (100_000),
    .FIFO_ADDR_SIZE  (4),
    .UART_DATA_WIDTH (8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wb       (wb),
    .uart_txd (uart_txd),
    .tx_irq   (tx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  int          fall_q[$];
  bit          mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor: every cycle of each frame is compared with the expected bit.
  logic [7:0]       mon_b;
  logic [NBITS-1:0] mon_fr;
  int               mon_bad;
  bit               mon_abort, mon_unexp;
  initial forever begin
    @(negedge clk);
    if (!resetn && uart_txd === 1'b0) begin
      mon_active = 1'b1;
      fall_q.push_back(cyc);
      mon_unexp = (exp_q.size() == 0);
      mon_b = mon_unexp ? 8'h00 : exp_q.pop_front();
      mon_fr = '0;
      for (int j = 0; j < 8; j++) mon_fr[1 + j] = mon_b[j];
`ifdef WB_UART_TX_PARITY_EN
      mon_fr[9] = ^mon_b;
`endif
      mon_fr[NBITS-1] = 1'b1;
      mon_bad = -1;
      mon_abort = 1'b0;
      for (int i = 0; i < FRAME_CYC; i++) begin
        if (i > 0) @(negedge clk);
        if (resetn) begin
          mon_abort = 1'b1;
          break;
        end
        if (uart_txd !== mon_fr[i / DIV] && mon_bad < 0) mon_bad = i;
      end
      mon_active = 1'b0;
      if (!mon_abort) begin
        checks++;
        if (mon_unexp) begin
          failures++;
          $display("FAIL frame: unexpected frame got txd activity expected idle");
        end else if (mon_bad >= 0) begin
          failures++;
          $display("FAIL frame 0x%02h: txd got %0b at frame cycle %0d expected %0b",
                   mon_b, ~mon_fr[mon_bad / DIV], mon_bad, mon_fr[mon_bad / DIV]);
        end
      end
    end
  end

  // Read monitor: a read strobe on edge N must be acked with data on edge N.
  logic rd_edge = 1'b0;
  always @(posedge clk) rd_edge <= wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_we_i;
  always @(negedge clk) begin
    if (rd_edge) begin
      if (rd_q.size() == 0) begin
        check("read_unexpected", 32'd1, 32'd0);
      end else begin
        check({rd_name_q[0], "_ack"}, {31'd0, wb.wb_ack_o}, 32'd1);
        check(rd_name_q[0], wb.wb_dat_o, rd_q[0]);
        void'(rd_q.pop_front());
        void'(rd_name_q.pop_front());
      end
    end
  end

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, output int edge_cyc);
    @(negedge clk);
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = AW'(adr); wb.wb_dat_i = dat;
    @(posedge clk);
    #1 edge_cyc = cyc;
    @(negedge clk);
    check("wr_ack", {31'd0, wb.wb_ack_o}, 32'd1);
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] adr, input logic [31:0] exp, input string name);
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    @(negedge clk);
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = AW'(adr);
    @(negedge clk);
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int max, input string name);
    int k = 0;
    while ((exp_q.size() != 0 || mon_active) && k < max) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain_timeout"}, {31'd0, k >= max}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  int e, f, dummy;
  initial begin
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_sel_i = 4'hF; wb.wb_adr_i = '0; wb.wb_dat_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    check("rst_irq", {31'd0, tx_irq}, 32'd0);
    resetn = 1'b0;
    wb_read(2'd1, 32'h0000_0001, "rst_status");
    wb_read(2'd0, 32'h0, "data_read");
    wb_read(2'd2, 32'h0, "ctrl_read");
    wb_read(2'd3, 32'h0, "rsvd_read");
    wb_write(2'd3, 32'hFFFF_FFFF, dummy);
    wb_read(2'd1, 32'h0000_0001, "rsvd_wr_status");

    // 1: single byte 0x55
    fall_q.delete();
    exp_q.push_back(8'h55);
    wb_write(2'd0, 32'h55, e);
    repeat (30) @(negedge clk);
    wb_read(2'd1, 32'h0000_0005, "t1_status");
    wait_drain(400, "t1");
    check("t1_fall_latency", (fall_q.size() > 0) ? fall_q[0] - e : -1, 32'd1);

    // 2: three back-to-back bytes, contiguous frames
    fall_q.delete();
    exp_q.push_back(8'hA1); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    wb_write(2'd0, 32'hA1, dummy);
    wb_write(2'd0, 32'h00, dummy);
    wb_write(2'd0, 32'hFF, dummy);
    wb_read(2'd1, 32'h0000_0204, "t2_status");
    wait_drain(800, "t2");
    check("t2_frames", fall_q.size(), 32'd3);
    if (fall_q.size() == 3) begin
      check("t2_gap1", fall_q[1] - fall_q[0], FRAME_CYC);
      check("t2_gap2", fall_q[2] - fall_q[0], 2 * FRAME_CYC);
    end

    // 3: overflow with 18 writes
    for (int i = 0; i < 18; i++) begin
      if (i < 17) exp_q.push_back(8'(8'h10 + i));
      wb_write(2'd0, 32'(8'h10 + i), dummy);
    end
    wb_read(2'd1, 32'h0000_100E, "t3_status_full");
    wb_write(2'd2, 32'h2, dummy);
    wb_read(2'd1, 32'h0000_1006, "t3_status_clr");
    wait_drain(2500, "t3");
    wb_read(2'd1, 32'h0000_0001, "t3_status_idle");

    // 4: flush during first frame
    exp_q.push_back(8'h3C);
    wb_write(2'd0, 32'h3C, dummy);
    wb_write(2'd0, 32'h11, dummy);
    wb_write(2'd0, 32'h22, dummy);
    wb_write(2'd0, 32'h33, dummy);
    wb_write(2'd0, 32'h44, dummy);
    repeat (20) @(negedge clk);
    wb_write(2'd2, 32'h1, dummy);
    wb_read(2'd1, 32'h0000_0005, "t4_status_flushed");
    wait_drain(400, "t4");
    fall_q.delete();
    repeat (150) @(negedge clk);
    check("t4_no_more_frames", fall_q.size(), 32'd0);
    wb_read(2'd1, 32'h0000_0001, "t4_status_idle");

    // 5: interrupt
    wb_write(2'd2, 32'h4, dummy);
    @(negedge clk);
    check("t5_irq_idle", {31'd0, tx_irq}, 32'd1);
    exp_q.push_back(8'h96);
    wb_write(2'd0, 32'h96, e);
    wait_until(e + 10);
    check("t5_irq_busy", {31'd0, tx_irq}, 32'd0);
    wait_until(e + FRAME_CYC + 1);
    check("t5_irq_stop_end", {31'd0, tx_irq}, 32'd0);
    wait_until(e + FRAME_CYC + 2);
    check("t5_irq_rise", {31'd0, tx_irq}, 32'd1);
    wb_write(2'd2, 32'h0, f);
    check("t5_irq_hold", {31'd0, tx_irq}, 32'd1);
    @(negedge clk);
    check("t5_irq_cleared", {31'd0, tx_irq}, 32'd0);

    // 6: reset mid data bit
    exp_q.push_back(8'hF0);
    wb_write(2'd0, 32'hF0, e);
    wait_until(e + 35);
    #3 resetn = 1'b1;
    #1 check("t6_txd_async", {31'd0, uart_txd}, 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    fall_q.delete();
    exp_q.delete();
    wb_read(2'd1, 32'h0000_0001, "t6_status");
    repeat (150) @(negedge clk);
    check("t6_no_frame", fall_q.size(), 32'd0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("rd_q_empty", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
